iact_csc_bank: RTL and testbench

- Parametrised successor of the GLB-cluster iact SRAM bank: one compressed-sparse-column (CSC) input-activation bank in the GLB cluster.
- Holds an address memory and a data memory internally (1R1W each). Each memory receives and replays one zero-terminated stream.
- Adds over the previous generation:
  - width/depth parameters;
  - independent read base per memory;
  - overflow detection;
  - abort;
  - word-count statistics.

---
 rtl/iact_csc_bank.sv | 200 ++++++++++++++++++++
 tb/tb_iact_csc_bank.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iact_csc_bank.sv
// iact_csc_bank: CSC input-activation bank holding one zero-terminated address stream and one data stream
// Ports: clock/reset_n; addr_in*/data_in* write streams; addr_out*/data_out* read streams;
//   write_en/write_done and read_en/addr_read_base/data_read_base/read_done job control;
//   abort kills both jobs; overflow is sticky; addr_wr_count/data_wr_count are live only with IACT_BANK_STAT_EN.
module iact_csc_bank #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 12,
  parameter int ADDR_DEPTH = 512,
  parameter int DATA_DEPTH = 1024,
  parameter int PTR_W      = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              addr_in_valid,
  output logic              addr_in_ready,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              addr_out_ready,
  output logic              addr_out_valid,
  output logic [ADDR_W-1:0] addr_out,
  input  logic              data_out_ready,
  output logic              data_out_valid,
  output logic [DATA_W-1:0] data_out,
  input  logic              write_en,
  output logic              write_done,
  input  logic              read_en,
  input  logic [PTR_W-1:0]  addr_read_base,
  input  logic [PTR_W-1:0]  data_read_base,
  output logic              read_done,
  input  logic              abort,
  output logic              overflow,
  output logic [PTR_W:0]    addr_wr_count,
  output logic [PTR_W:0]    data_wr_count
);
  localparam int AA = $clog2(ADDR_DEPTH);
  localparam int DA = $clog2(DATA_DEPTH);
  localparam logic [PTR_W:0]   A_DEP   = (PTR_W+1)'(ADDR_DEPTH);
  localparam logic [PTR_W:0]   D_DEP   = (PTR_W+1)'(DATA_DEPTH);
  localparam logic [PTR_W:0]   A_WLAST = (PTR_W+1)'(ADDR_DEPTH-1);
  localparam logic [PTR_W:0]   D_WLAST = (PTR_W+1)'(DATA_DEPTH-1);
  localparam logic [PTR_W-1:0] A_RLAST = PTR_W'(ADDR_DEPTH-1);
  localparam logic [PTR_W-1:0] D_RLAST = PTR_W'(DATA_DEPTH-1);
  localparam logic [PTR_W:0]   W_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] R_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_WORK, W_WAIT_ADDR, W_WAIT_DATA} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WORK, R_WAIT_ADDR, R_WAIT_DATA} r_state_t;

  logic [ADDR_W-1:0] amem [ADDR_DEPTH];
  logic [DATA_W-1:0] dmem [DATA_DEPTH];
  logic [ADDR_W-1:0] a_mem_rd;
  logic [DATA_W-1:0] d_mem_rd;

  w_state_t       w_q, w_d;
  logic [PTR_W:0] awp_q, awp_d, dwp_q, dwp_d;
  logic           ovf_q, ovf_d, wdone_q, wdone_d;
  logic           a_wact, d_wact, a_whs, d_whs, a_wend, d_wend, a_wleft, d_wleft;

  r_state_t          r_q, r_d;
  logic [PTR_W-1:0]  arp_q, arp_d, drp_q, drp_d;
  logic              arv_q, arv_d, drv_q, drv_d, aov_q, aov_d, dov_q, dov_d, rdone_q, rdone_d;
  logic [ADDR_W-1:0] aout_q, aout_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              a_ract, d_ract, a_rend, d_rend, a_rleft, d_rleft;
  logic              a_load, d_load, a_iss, d_iss;

  assign a_wact        = (w_q == W_WORK) || (w_q == W_WAIT_ADDR);
  assign d_wact        = (w_q == W_WORK) || (w_q == W_WAIT_DATA);
  assign addr_in_ready = a_wact && (awp_q < A_DEP);
  assign data_in_ready = d_wact && (dwp_q < D_DEP);
  assign a_whs         = addr_in_valid && addr_in_ready;
  assign d_whs         = data_in_valid && data_in_ready;
  // Filling the last entry ends the channel even without a terminator.
  assign a_wend        = a_whs && (addr_in == '0 || awp_q == A_WLAST);
  assign d_wend        = d_whs && (data_in == '0 || dwp_q == D_WLAST);
  assign a_wleft       = a_wact && !a_wend;
  assign d_wleft       = d_wact && !d_wend;

  always_comb begin
    w_d     = w_q;
    awp_d   = a_whs ? awp_q + W_ONE : awp_q;
    dwp_d   = d_whs ? dwp_q + W_ONE : dwp_q;
    ovf_d   = ovf_q || (a_whs && addr_in != '0 && awp_q == A_WLAST)
                    || (d_whs && data_in != '0 && dwp_q == D_WLAST);
    wdone_d = 1'b0;
    if (abort) w_d = W_IDLE;
    else if (w_q == W_IDLE) begin
      if (write_en) begin
        w_d   = W_WORK;
        awp_d = '0;
        dwp_d = '0;
        ovf_d = 1'b0;
      end
    end else begin
      w_d     = a_wleft ? (d_wleft ? W_WORK : W_WAIT_ADDR) : (d_wleft ? W_WAIT_DATA : W_IDLE);
      wdone_d = !a_wleft && !d_wleft;
    end
  end

  // Read pipeline per channel: memory read register then output register; a
  // fetch is issued only when the memory register is free or drains this cycle.
  assign a_ract  = (r_q == R_WORK) || (r_q == R_WAIT_ADDR);
  assign d_ract  = (r_q == R_WORK) || (r_q == R_WAIT_DATA);
  assign a_rend  = aov_q && addr_out_ready && aout_q == '0;
  assign d_rend  = dov_q && data_out_ready && dout_q == '0;
  assign a_rleft = a_ract && !a_rend;
  assign d_rleft = d_ract && !d_rend;
  assign a_load  = arv_q && (!aov_q || addr_out_ready);
  assign d_load  = drv_q && (!dov_q || data_out_ready);
  assign a_iss   = a_ract && (!arv_q || a_load);
  assign d_iss   = d_ract && (!drv_q || d_load);

  always_comb begin
    r_d     = r_q;
    arp_d   = a_iss ? ((arp_q == A_RLAST) ? '0 : arp_q + R_ONE) : arp_q;
    drp_d   = d_iss ? ((drp_q == D_RLAST) ? '0 : drp_q + R_ONE) : drp_q;
    aout_d  = a_load ? a_mem_rd : aout_q;
    dout_d  = d_load ? d_mem_rd : dout_q;
    // Words fetched past a terminator are discarded when the channel ends.
    arv_d   = !(abort || a_rend) && (a_iss || (arv_q && !a_load));
    drv_d   = !(abort || d_rend) && (d_iss || (drv_q && !d_load));
    aov_d   = !(abort || a_rend) && (a_load || (aov_q && !addr_out_ready));
    dov_d   = !(abort || d_rend) && (d_load || (dov_q && !data_out_ready));
    rdone_d = 1'b0;
    if (abort) r_d = R_IDLE;
    else if (r_q == R_IDLE) begin
      if (read_en) begin
        r_d   = R_WORK;
        arp_d = addr_read_base;
        drp_d = data_read_base;
      end
    end else begin
      r_d     = a_rleft ? (d_rleft ? R_WORK : R_WAIT_ADDR) : (d_rleft ? R_WAIT_DATA : R_IDLE);
      rdone_d = !a_rleft && !d_rleft;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_q     <= W_IDLE;
      awp_q   <= '0;
      dwp_q   <= '0;
      ovf_q   <= 1'b0;
      wdone_q <= 1'b0;
      r_q     <= R_IDLE;
      arp_q   <= '0;
      drp_q   <= '0;
      arv_q   <= 1'b0;
      drv_q   <= 1'b0;
      aov_q   <= 1'b0;
      dov_q   <= 1'b0;
      aout_q  <= '0;
      dout_q  <= '0;
      rdone_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      awp_q   <= awp_d;
      dwp_q   <= dwp_d;
      ovf_q   <= ovf_d;
      wdone_q <= wdone_d;
      r_q     <= r_d;
      arp_q   <= arp_d;
      drp_q   <= drp_d;
      arv_q   <= arv_d;
      drv_q   <= drv_d;
      aov_q   <= aov_d;
      dov_q   <= dov_d;
      aout_q  <= aout_d;
      dout_q  <= dout_d;
      rdone_q <= rdone_d;
    end
  end

  // Non-blocking memory update gives old data on a same-entry read/write.
  always_ff @(posedge clock) begin
    if (a_whs) amem[awp_q[AA-1:0]] <= addr_in;
    if (d_whs) dmem[dwp_q[DA-1:0]] <= data_in;
    if (a_iss) a_mem_rd <= amem[arp_q[AA-1:0]];
    if (d_iss) d_mem_rd <= dmem[drp_q[DA-1:0]];
  end

  assign write_done     = wdone_q;
  assign read_done      = rdone_q;
  assign overflow       = ovf_q;
  assign addr_out_valid = aov_q;
  assign data_out_valid = dov_q;
  assign addr_out       = aout_q;
  assign data_out       = dout_q;

`ifdef IACT_BANK_STAT_EN
  // Write pointers start at zero and advance once per accepted word, so they are the counts.
  assign addr_wr_count = awp_q;
  assign data_wr_count = dwp_q;
`else
  assign addr_wr_count = '0;
  assign data_wr_count = '0;
`endif
endmodule

// File: tb/tb_iact_csc_bank.sv
// tb_iact_csc_bank: scoreboard bench for iact_csc_bank with a small-depth configuration
module tb_iact_csc_bank;
  localparam int AD = 4;
  localparam int DD = 8;
  localparam int PW = 3;
`ifdef IACT_BANK_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clock = 1'b0, reset_n = 1'b0;
  logic addr_in_valid = 1'b0, data_in_valid = 1'b0, addr_out_ready = 1'b0, data_out_ready = 1'b0;
  logic addr_in_ready, data_in_ready, addr_out_valid, data_out_valid;
  logic [6:0] addr_in = '0, addr_out;
  logic [11:0] data_in = '0, data_out;
  logic write_en = 1'b0, read_en = 1'b0, abort = 1'b0, write_done, read_done, overflow;
  logic [PW-1:0] addr_read_base = '0, data_read_base = '0;
  logic [PW:0] addr_wr_count, data_wr_count;

  always #5 clock = ~clock;

  iact_csc_bank #(.ADDR_W(7), .DATA_W(12), .ADDR_DEPTH(AD), .DATA_DEPTH(DD), .PTR_W(PW)) dut (
    .clock(clock), .reset_n(reset_n),
    .addr_in_valid(addr_in_valid), .addr_in_ready(addr_in_ready), .addr_in(addr_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in(data_in),
    .addr_out_ready(addr_out_ready), .addr_out_valid(addr_out_valid), .addr_out(addr_out),
    .data_out_ready(data_out_ready), .data_out_valid(data_out_valid), .data_out(data_out),
    .write_en(write_en), .write_done(write_done), .read_en(read_en),
    .addr_read_base(addr_read_base), .data_read_base(data_read_base), .read_done(read_done),
    .abort(abort), .overflow(overflow), .addr_wr_count(addr_wr_count), .data_wr_count(data_wr_count)
  );

  int checks = 0, errors = 0, cyc = 0;
  int wd_n = 0, wd_cyc = 0, rd_n = 0, rd_cyc = 0, first_a = -1, first_d = -1;
  int a_term_cyc = 0, d_term_cyc = 0, a_acc = 0, d_acc = 0, a_hs_cyc = 0, d_hs_cyc = 0;
  int rmode = 0;
  bit wgap = 1'b0;
  logic [6:0] exp_aq[$];
  logic [11:0] exp_dq[$];
  logic [6:0] am[AD];
  logic [11:0] dm[DD];
  bit ak[AD];
  bit dk[DD];
  logic p_av = 0, p_ar = 0, p_dv = 0, p_dr = 0, p_abort = 0;
  logic [6:0] p_a = '0;
  logic [11:0] p_d = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clock) begin
    logic [6:0] ea;
    logic [11:0] ed;
    if (addr_out_valid && addr_out_ready) begin
      if (exp_aq.size() == 0) chk("addr_out_extra", {25'd0, addr_out}, 32'hffff_ffff);
      else begin
        ea = exp_aq.pop_front();
        chk("addr_out", {25'd0, addr_out}, {25'd0, ea});
        if (ea == 0) a_term_cyc = cyc + 1;
      end
    end
    if (data_out_valid && data_out_ready) begin
      if (exp_dq.size() == 0) chk("data_out_extra", {20'd0, data_out}, 32'hffff_ffff);
      else begin
        ed = exp_dq.pop_front();
        chk("data_out", {20'd0, data_out}, {20'd0, ed});
        if (ed == 0) d_term_cyc = cyc + 1;
      end
    end
    if (addr_out_valid && first_a < 0) first_a = cyc;
    if (data_out_valid && first_d < 0) first_d = cyc;
    if (p_av && !p_ar && !p_abort) chk("addr_hold", {addr_out_valid, addr_out}, {1'b1, p_a});
    if (p_dv && !p_dr && !p_abort) chk("data_hold", {data_out_valid, data_out}, {1'b1, p_d});
    if (write_done) begin wd_n++; wd_cyc = cyc; end
    if (read_done) begin rd_n++; rd_cyc = cyc; end
    p_av = addr_out_valid; p_ar = addr_out_ready; p_a = addr_out;
    p_dv = data_out_valid; p_dr = data_out_ready; p_d = data_out;
    p_abort = abort;
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        0: begin addr_out_ready = 1'b1; data_out_ready = 1'b1; end
        1: begin addr_out_ready = ~addr_out_ready; data_out_ready = ~data_out_ready; end
        2: begin addr_out_ready = 1'($urandom_range(0, 1)); data_out_ready = 1'($urandom_range(0, 1)); end
        default: begin addr_out_ready = 1'b0; data_out_ready = 1'b0; end
      endcase
    end
  end

  task automatic drv_a(input logic [6:0] w[$], input int dly);
    a_acc = 0;
    repeat (dly) @(posedge clock);
    #1;
    foreach (w[i]) begin
      int t;
      t = 0;
      addr_in = w[i];
      addr_in_valid = 1'b1;
      @(negedge clock);
      while (!addr_in_ready && t < 20) begin @(negedge clock); t++; end
      if (!addr_in_ready) break;
      @(posedge clock);
      #1;
      a_acc++;
      a_hs_cyc = cyc;
      addr_in_valid = 1'b0;
      if (wgap) repeat ($urandom_range(0, 1)) begin @(posedge clock); #1; end
    end
    addr_in_valid = 1'b0;
  endtask

  task automatic drv_d(input logic [11:0] w[$], input int dly);
    d_acc = 0;
    repeat (dly) @(posedge clock);
    #1;
    foreach (w[i]) begin
      int t;
      t = 0;
      data_in = w[i];
      data_in_valid = 1'b1;
      @(negedge clock);
      while (!data_in_ready && t < 20) begin @(negedge clock); t++; end
      if (!data_in_ready) break;
      @(posedge clock);
      #1;
      d_acc++;
      d_hs_cyc = cyc;
      data_in_valid = 1'b0;
      if (wgap) repeat ($urandom_range(0, 1)) begin @(posedge clock); #1; end
    end
    data_in_valid = 1'b0;
  endtask

  task automatic write_job(input logic [6:0] aw[$], input logic [11:0] dw[$], input int adly, input int ddly);
    int na, nd, w0;
    bit ao, dov;
    na = 0; nd = 0; ao = 0; dov = 0; w0 = wd_n;
    for (int i = 0; i < aw.size(); i++) begin
      am[i] = aw[i]; ak[i] = 1; na++;
      if (aw[i] == 0) break;
      if (na == AD) begin ao = 1; break; end
    end
    for (int i = 0; i < dw.size(); i++) begin
      dm[i] = dw[i]; dk[i] = 1; nd++;
      if (dw[i] == 0) break;
      if (nd == DD) begin dov = 1; break; end
    end
    write_en = 1'b1;
    @(posedge clock);
    #1 write_en = 1'b0;
    fork
      begin drv_a(aw, adly); @(negedge clock); chk("addr_ready_after_end", addr_in_ready, 0); end
      begin drv_d(dw, ddly); @(negedge clock); chk("data_ready_after_end", data_in_ready, 0); end
    join
    repeat (3) @(negedge clock);
    chk("addr_accepted", a_acc, na);
    chk("data_accepted", d_acc, nd);
    chk("write_done_count", wd_n - w0, 1);
    chk("write_done_cycle", wd_cyc, (a_hs_cyc > d_hs_cyc) ? a_hs_cyc : d_hs_cyc);
    chk("overflow", overflow, ao || dov);
    chk("addr_wr_count", addr_wr_count, STAT ? na : 0);
    chk("data_wr_count", data_wr_count, STAT ? nd : 0);
  endtask

  task automatic read_job(input int ab, input int db, input int mode);
    int b, na, nd, c0, r0, t;
    na = 0; nd = 0; r0 = rd_n; t = 0;
    exp_aq.delete();
    exp_dq.delete();
    b = ab;
    for (int k = 0; k < AD; k++) begin
      exp_aq.push_back(am[b]); na++;
      if (am[b] == 0) break;
      b = (b + 1) % AD;
    end
    b = db;
    for (int k = 0; k < DD; k++) begin
      exp_dq.push_back(dm[b]); nd++;
      if (dm[b] == 0) break;
      b = (b + 1) % DD;
    end
    rmode = mode;
    first_a = -1;
    first_d = -1;
    addr_read_base = PW'(ab);
    data_read_base = PW'(db);
    read_en = 1'b1;
    @(posedge clock);
    #1;
    c0 = cyc;
    read_en = 1'b0;
    while ((exp_aq.size() != 0 || exp_dq.size() != 0 || rd_n == r0) && t < 400) begin
      @(negedge clock);
      t++;
    end
    repeat (4) @(negedge clock);
    chk("read_done_count", rd_n - r0, 1);
    chk("addr_words_left", exp_aq.size(), 0);
    chk("data_words_left", exp_dq.size(), 0);
    chk("addr_first_valid", first_a, c0 + 2);
    chk("data_first_valid", first_d, c0 + 2);
    chk("read_done_cycle", rd_cyc, (a_term_cyc > d_term_cyc) ? a_term_cyc : d_term_cyc);
    if (mode == 0) begin
      chk("addr_full_rate", a_term_cyc, c0 + 2 + na);
      chk("data_full_rate", d_term_cyc, c0 + 2 + nd);
    end
  endtask

  function automatic int find_a(input int s);
    for (int o = 0; o < AD; o++) begin
      int b;
      b = (s + o) % AD;
      for (int k = 0; k < AD; k++) begin
        if (!ak[b]) break;
        if (am[b] == 0) return (s + o) % AD;
        b = (b + 1) % AD;
      end
    end
    return -1;
  endfunction

  function automatic int find_d(input int s);
    for (int o = 0; o < DD; o++) begin
      int b;
      b = (s + o) % DD;
      for (int k = 0; k < DD; k++) begin
        if (!dk[b]) break;
        if (dm[b] == 0) return (s + o) % DD;
        b = (b + 1) % DD;
      end
    end
    return -1;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_addr_in_ready"}, addr_in_ready, 0);
    chk({tag, "_data_in_ready"}, data_in_ready, 0);
    chk({tag, "_addr_out_valid"}, addr_out_valid, 0);
    chk({tag, "_data_out_valid"}, data_out_valid, 0);
    chk({tag, "_addr_out"}, {25'd0, addr_out}, 0);
    chk({tag, "_data_out"}, {20'd0, data_out}, 0);
    chk({tag, "_dones"}, {write_done, read_done}, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_counts"}, {addr_wr_count, data_wr_count}, 0);
  endtask

  initial begin
    logic [6:0] aq[$];
    logic [11:0] dq[$];
    int r0, fa, fd;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_checks("reset");
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    reset_checks("post_reset");

    aq.push_back(7'd3); aq.push_back(7'd5); aq.push_back(7'd0);
    dq.push_back(12'h011); dq.push_back(12'h022); dq.push_back(12'h033); dq.push_back(12'h000);
    write_job(aq, dq, 0, 0);
    read_job(0, 0, 0);
    write_job(aq, dq, 12, 0);
    read_job(0, 1, 0);
    read_job(0, 1, 1);

    exp_aq.delete();
    exp_dq.delete();
    rmode = 3;
    r0 = rd_n;
    addr_read_base = '0;
    data_read_base = '0;
    read_en = 1'b1;
    @(posedge clock);
    #1 read_en = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort_valid_before", {addr_out_valid, data_out_valid}, 2'b11);
    @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    chk("abort_valid_after", {addr_out_valid, data_out_valid}, 2'b00);
    repeat (10) @(negedge clock);
    chk("abort_no_read_done", rd_n - r0, 0);
    read_job(0, 0, 2);

    aq.delete(); dq.delete();
    aq.push_back(7'd1); aq.push_back(7'd2); aq.push_back(7'd3); aq.push_back(7'd4);
    dq.push_back(12'h005); dq.push_back(12'h006); dq.push_back(12'h000);
    write_job(aq, dq, 0, 8);

    wgap = 1'b1;
    for (int it = 0; it < 10; it++) begin
      int n;
      aq.delete(); dq.delete();
      if ($urandom_range(0, 3) == 0) repeat (AD) aq.push_back(7'($urandom_range(1, 127)));
      else begin
        n = $urandom_range(0, AD - 1);
        repeat (n) aq.push_back(7'($urandom_range(1, 127)));
        aq.push_back(7'd0);
      end
      if ($urandom_range(0, 3) == 0) repeat (DD) dq.push_back(12'($urandom_range(1, 4095)));
      else begin
        n = $urandom_range(0, DD - 1);
        repeat (n) dq.push_back(12'($urandom_range(1, 4095)));
        dq.push_back(12'd0);
      end
      write_job(aq, dq, $urandom_range(0, 3), $urandom_range(0, 3));
      fa = find_a($urandom_range(0, AD - 1));
      fd = find_d($urandom_range(0, DD - 1));
      if (fa >= 0 && fd >= 0) read_job(fa, fd, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
